irq_pending_latch: RTL
======================

# irq_pending_latch

Captures eight interrupt request lines into a pending register and masks them. Selects the highest-index pending request and offers its 3-bit index to a downstream consumer over a valid/ready handshake. This is the sequential front end that feeds the 8-to-3 priority encoding path: it turns raw, asynchronous-to-logic request pulses into held, one-at-a-time, acknowledged events. The pending vector is also exported so the combinational priority encoder can be driven directly.

## Interface
- SYNC_STAGES, 2: input synchronizer depth per request line; legal range 1..3.
- LEVEL_MODE, 0: 0 = rising-edge latched requests; 1 = level requests, where pending mirrors the synchronized level.
- clk  input  1  sole clock; all flops update on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- irq_in  input  8  raw request lines; bit i is request i; higher index has higher priority.
- mask_in  input  8  enable per line; 1 = eligible for offer.
- irq_valid  output  1  an index is being offered.
- irq_id  output  3  offered index; stable while irq_valid=1.
- irq_ready  input  1  consumer accepts the offer when irq_valid=1.
- pending  output  8  raw pending register (unmasked view).
- ovf  output  1  sticky flag: an edge arrived on a line whose pending bit was already set.
- ovf_clr  input  1  clears ovf.

## Operation
- Synchronizer: SYNC_STAGES flops per bit, followed by one "previous" flop. Edge = last stage & ~previous.
- Edge mode: an edge sets pending[i]. Acceptance (irq_valid & irq_ready) clears pending[irq_id]. A set and a clear on the same bit in the same cycle leave it set.
- Level mode: pending[i] = last sync stage. Acceptance does not modify pending. ovf is never set.
- eligible = pending & mask_in. Masked bits stay latched and become eligible when unmasked.
- FSM has two states: IDLE and OFFER.
  - IDLE: if eligible != 0, load irq_id with the highest set index of eligible, set irq_valid, and go to OFFER. Otherwise stay in IDLE.
  - OFFER: hold irq_valid=1 and irq_id until acceptance; then go to IDLE with irq_valid=0.
  - No preemption: a higher-priority arrival does not change irq_id.
  - Mask or pending changes during OFFER do not withdraw the offer.
- After acceptance there is always one IDLE cycle with irq_valid=0 before the next offer.
- ovf: set when edge[i] & pending[i] (edge mode), including on the bit being cleared in that cycle. Cleared by ovf_clr. Set wins over clear.
- Reset (rst_n=0 at an edge) clears everything, including mid-offer:
  - sync and previous flops = 0.
  - pending = 0, ovf = 0, irq_valid = 0, irq_id = 0, FSM = IDLE.
  - A line held high through reset release produces one edge.

## Timing
- Request sampled at edge k: pending[i]=1 after edge k+SYNC_STAGES, and irq_valid=1 after edge k+SYNC_STAGES+1. Latency is SYNC_STAGES+1 cycles.
- Acceptance at edge a: irq_valid=0 and pending bit cleared after edge a. The earliest next offer is after edge a+1.
- Maximum throughput is one accepted index per 2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- The sustained request pulse width must be at least 1 clk for a reliable capture. Shorter pulses are undefined.

## Structure
- Shared package irq_pkg holds:
  - IRQ_LINES = 8 and IRQ_ID_W = 3.
  - The FSM state enum (ST_IDLE, ST_OFFER).
  - A function returning the highest set index of an 8-bit vector.
- Sub-module irq_sync_edge: parameterized synchronizer plus previous flop, one instance of width 8. It outputs the synchronized level and the edge pulse.
- Top level holds the pending and ovf registers, the FSM, and the output registers.

## Test plan
- Single edge: SYNC_STAGES=2, pulse irq_in=8'h08 for 1 cycle at edge k, irq_ready=1, mask=8'hFF → irq_valid high after k+3 with irq_id=3. pending returns to 0 after acceptance.
- Priority/no-preempt: irq_in edges on bits 1 and 5 together, irq_ready=0 → irq_id=5 held. Then an edge on bit 7 arrives; irq_id stays 5. Ready high → offers 7 then 1, in that order, each separated by one idle cycle.
- Masking: edge on bit 6 with mask_in=8'hBF → pending=8'h40 and irq_valid stays 0. Set mask bit 6 → offer id 6 one cycle later.
- Overflow/simultaneity: second edge on bit 2 while pending[2]=1 → ovf=1. An edge on bit 2 in the acceptance cycle of id 2 → pending[2] stays 1 and ovf=1. Then ovf_clr → ovf=0.
- Reset mid-offer: in OFFER with id 4, drive rst_n=0 for one edge → next cycle all outputs 0 and pending=0. irq_in[0] held high across release → id 0 offered after SYNC_STAGES+1 cycles.
- Level mode: LEVEL_MODE=1, hold irq_in[3]=1 → repeated offers of id 3 every 2 cycles with ready high. Drop the line → pending[3]=0 after SYNC_STAGES cycles and offers stop.

Source files
------------

// File: rtl/irq_pkg.sv
// irq_pkg: shared constants, FSM state type and priority helper for the
// interrupt pending-latch front end.
//   IRQ_LINES   number of request lines
//   IRQ_ID_W    width of an offered index
//   irq_state_e offer FSM state
//   highest_idx highest set bit index of a line vector (0 for an empty vector)
package irq_pkg;

  localparam int IRQ_LINES = 8;
  localparam int IRQ_ID_W  = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } irq_state_e;

  // Ascending scan; the last hit wins, so the highest index is returned.
  function automatic logic [IRQ_ID_W-1:0] highest_idx(input logic [IRQ_LINES-1:0] v);
    logic [IRQ_ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < IRQ_LINES; i++)
      if (v[i]) idx = IRQ_ID_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/irq_pending_latch_if.sv
// irq_pending_latch_if: valid/ready offer channel carrying an interrupt index.
//   irq_valid  producer -> consumer, an index is offered
//   irq_id     producer -> consumer, offered index, stable while irq_valid=1
//   irq_ready  consumer -> producer, accepts the offer when irq_valid=1
interface irq_pending_latch_if;

  logic                         irq_valid;
  logic [irq_pkg::IRQ_ID_W-1:0] irq_id;
  logic                         irq_ready;

  modport master (output irq_valid, output irq_id, input  irq_ready);
  modport slave  (input  irq_valid, input  irq_id, output irq_ready);

endinterface

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: per-bit multi-flop synchronizer followed by a "previous"
// flop used for rising-edge detection.
//   clk, rst_n  clock, synchronous active-low reset
//   d           raw asynchronous inputs
//   level       synchronized level (last synchronizer stage)
//   rise        one-cycle pulse: level & ~previous
module irq_sync_edge #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0]             prev_q;

  // Clearing prev_q in reset means a line held high through release is seen
  // as exactly one rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= d;
      for (int s = 1; s < STAGES; s++)
        sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_pending_latch.sv
// irq_pending_latch: latches 8 request lines into a pending register, masks
// them, and offers the highest-index eligible request one at a time over a
// valid/ready channel.
//   clk, rst_n  clock, synchronous active-low reset
//   irq_in      raw request lines (higher index = higher priority)
//   mask_in     per-line enable for offering
//   ovf_clr     clears the sticky overflow flag
//   pending     raw pending register (unmasked)
//   ovf         sticky: an edge hit a line already pending
//   irq         offer channel (irq_valid / irq_id / irq_ready)
module irq_pending_latch
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit LEVEL_MODE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IRQ_LINES-1:0] irq_in,
  input  logic [IRQ_LINES-1:0] mask_in,
  input  logic                 ovf_clr,
  output logic [IRQ_LINES-1:0] pending,
  output logic                 ovf,
  irq_pending_latch_if.master  irq
);

  logic [IRQ_LINES-1:0] lvl, rise, eligible, clr_vec, pend_q;
  logic [IRQ_ID_W-1:0]  id_q;
  logic                 valid_q, ovf_q, accept;
  irq_state_e           state_q;

  irq_sync_edge #(
    .W      (IRQ_LINES),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (irq_in),
    .level (lvl),
    .rise  (rise)
  );

  assign accept   = valid_q & irq.irq_ready;
  assign eligible = pend_q & mask_in;
  assign clr_vec  = accept ? (IRQ_LINES'(1) << id_q) : '0;

  // Set is OR'd in after the clear so a same-cycle edge on the accepted
  // line keeps it pending; overflow looks at the pre-clear pending value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else if (LEVEL_MODE) begin
      pend_q <= lvl;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= (pend_q & ~clr_vec) | rise;
      ovf_q  <= (|(rise & pend_q)) | (ovf_q & ~ovf_clr);
    end
  end

  // Offer FSM: an offer is never withdrawn or re-targeted until accepted,
  // and acceptance always returns through IDLE for one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|eligible) begin
            id_q    <= highest_idx(eligible);
            valid_q <= 1'b1;
            state_q <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (accept) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pending       = pend_q;
  assign ovf           = ovf_q;
  assign irq.irq_valid = valid_q;
  assign irq.irq_id    = id_q;

endmodule
